// File: rtl/dwc_window_3x3.sv
// 3x3 stride-1 window former fed by a 3-line column stream; tracks row/column and flags end of frame.
// Optional "same" horizontal zero padding is enabled by defining DWC_WIN_PAD_EN.
module dwc_window_3x3 #(
    parameter int DWIDTH = 8,
    parameter int P_CH   = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [3*DWIDTH*P_CH-1:0]   Line3_Inputs,
    input  logic                       Line3_Inputs_Valid,
    input  logic [7:0]                 Feature_Width,
    input  logic                       Feature_Width_Valid,
    input  logic [7:0]                 Feature_Height,
    input  logic                       Feature_Height_Valid,
    output logic [9*DWIDTH*P_CH-1:0]   Window_Outputs,
    output logic                       Window_Outputs_Valid,
    output logic [7:0]                 Window_Col,
    output logic [7:0]                 Window_Row,
    output logic                       Frame_Done
);
    localparam int LW = DWIDTH * P_CH;

`ifdef DWC_WIN_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t            r_state;
    logic [7:0]        r_width;
    logic [7:0]        r_height;
    logic [7:0]        r_col;
    logic [7:0]        r_row;
    logic [3*LW-1:0]   r_c1;
    logic [3*LW-1:0]   r_c2;
    logic [9*LW-1:0]   r_window;
    logic              r_win_valid;
    logic [7:0]        r_win_col;
    logic [7:0]        r_win_row;
    logic              r_frame_done;

    logic              w_last_col;
    logic              w_last_row;

    assign w_last_col = (r_col == r_width - 8'd1);
    assign w_last_row = (r_row == r_height - 8'd3);

    // Place three columns (left, centre, right) into row-major window slots r*3+c.
    function automatic logic [9*LW-1:0] assemble(input logic [3*LW-1:0] left,
                                                 input logic [3*LW-1:0] mid,
                                                 input logic [3*LW-1:0] right);
        logic [9*LW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            w[(r*3+0)*LW +: LW] = left[r*LW +: LW];
            w[(r*3+1)*LW +: LW] = mid[r*LW +: LW];
            w[(r*3+2)*LW +: LW] = right[r*LW +: LW];
        end
        return w;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_width      <= '0;
            r_height     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            // NOTE: shift registers are reset too, so an aborted frame leaves no stale columns behind.
            r_c1         <= '0;
            r_c2         <= '0;
            r_window     <= '0;
            r_win_valid  <= 1'b0;
            r_win_col    <= '0;
            r_win_row    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking updates; every branch below reads the pre-edge register values.
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Feature_Width_Valid && Feature_Height_Valid) begin
                        r_width  <= Feature_Width;
                        r_height <= Feature_Height;
                        r_state  <= (Feature_Width < 8'd3 || Feature_Height < 8'd3) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (Line3_Inputs_Valid) begin
                        if (r_col == 8'd0) begin
                            r_c2 <= Line3_Inputs;
                            if (PAD_EN) begin
                                r_c1 <= '0;
                                // First beat of a new row closes the previous row with its right-pad window.
                                if (r_row != 8'd0) begin
                                    r_win_valid <= 1'b1;
                                    r_window    <= assemble(r_c1, r_c2, '0);
                                    r_win_col   <= r_width - 8'd1;
                                    r_win_row   <= r_row - 8'd1;
                                end
                            end
                        end else begin
                            r_c1 <= r_c2;
                            r_c2 <= Line3_Inputs;
                            if (PAD_EN || r_col >= 8'd2) begin
                                r_win_valid <= 1'b1;
                                r_window    <= assemble(r_c1, r_c2, Line3_Inputs);
                                r_win_col   <= r_col - 8'd1;
                                r_win_row   <= r_row;
                            end
                        end
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_row) begin
                                r_state <= PAD_EN ? S_FLUSH : S_DONE;
                            end else begin
                                r_row <= r_row + 8'd1;
                            end
                        end else begin
                            r_col <= r_col + 8'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    r_win_valid <= 1'b1;
                    r_window    <= assemble(r_c1, r_c2, '0);
                    r_win_col   <= r_width - 8'd1;
                    r_win_row   <= r_row;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_frame_done <= 1'b1;
                    r_width      <= '0;
                    r_height     <= '0;
                    r_col        <= '0;
                    r_row        <= '0;
                    r_c1         <= '0;
                    r_c2         <= '0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Window_Outputs       = r_window;
    assign Window_Outputs_Valid = r_win_valid;
    assign Window_Col           = r_win_col;
    assign Window_Row           = r_win_row;
    assign Frame_Done           = r_frame_done;

endmodule

// File: tb/tb_dwc_window_3x3.sv
// Self-checking bench for dwc_window_3x3 (DWIDTH=8, P_CH=1): frame table, random frames, abort and tiny-frame sequences.
// Expected windows come from a pixel-array model; follows DWC_WIN_PAD_EN like the design.
module tb_dwc_window_3x3;
    localparam int DW = 8;
    localparam int PC = 1;
    localparam int LW = DW * PC;

`ifdef DWC_WIN_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [3*LW-1:0]   Line3_Inputs = '0;
    logic              Line3_Inputs_Valid = 1'b0;
    logic [7:0]        Feature_Width = '0;
    logic              Feature_Width_Valid = 1'b0;
    logic [7:0]        Feature_Height = '0;
    logic              Feature_Height_Valid = 1'b0;
    logic [9*LW-1:0]   Window_Outputs;
    logic              Window_Outputs_Valid;
    logic [7:0]        Window_Col;
    logic [7:0]        Window_Row;
    logic              Frame_Done;

    dwc_window_3x3 #(.DWIDTH(DW), .P_CH(PC)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .Line3_Inputs         (Line3_Inputs),
        .Line3_Inputs_Valid   (Line3_Inputs_Valid),
        .Feature_Width        (Feature_Width),
        .Feature_Width_Valid  (Feature_Width_Valid),
        .Feature_Height       (Feature_Height),
        .Feature_Height_Valid (Feature_Height_Valid),
        .Window_Outputs       (Window_Outputs),
        .Window_Outputs_Valid (Window_Outputs_Valid),
        .Window_Col           (Window_Col),
        .Window_Row           (Window_Row),
        .Frame_Done           (Frame_Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      row;
        logic [7:0]      col;
        logic [9*LW-1:0] win;
    } exp_t;

    typedef struct {
        int w;
        int h;
        int gap;        // idle cycles before each beat; -1 = random 0..2
        bit rnd;        // random pixels instead of 16*row+col
        int strobe_at;  // beat index carrying a stray W=9/H=9 config strobe; -1 = none
        int exp_nopad;
        int exp_pad;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          win_cnt = 0;
    int          done_cnt = 0;
    int          last_valid_cyc = 0;
    int          done_cyc = 0;
    int          strobe_cyc = 0;
    int          win_base = 0;
    logic [9*LW-1:0] first_win = '0;
    logic [7:0]  pix [0:15][0:15];
    exp_t        exp_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor, sampled on the falling edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (Window_Outputs_Valid) begin
            win_cnt++;
            last_valid_cyc = cyc;
            if (win_cnt == win_base + 1) first_win = Window_Outputs;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_window: got row=%0d col=%0d, required no window", Window_Row, Window_Col);
            end else begin
                e = exp_q.pop_front();
                check("window_row_col_data", {Window_Row, Window_Col, Window_Outputs}, {e.row, e.col, e.win});
            end
        end
        if (Frame_Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference: every window centre of every row triple, out-of-frame columns read as zero.
    task automatic build_frame(input int w, input int h, input bit rnd);
        exp_t e;
        int   lo, hi, col;
        exp_q.delete();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                pix[r][c] = rnd ? 8'($urandom) : 8'(16 * r + c);
        if (w < 3 || h < 3) return;
        lo = PAD ? 0 : 1;
        hi = PAD ? w - 1 : w - 2;
        for (int rr = 0; rr <= h - 3; rr++) begin
            for (int ctr = lo; ctr <= hi; ctr++) begin
                e.row = 8'(rr);
                e.col = 8'(ctr);
                e.win = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        col = ctr - 1 + c;
                        if (col >= 0 && col < w) e.win[(r*3+c)*LW +: LW] = pix[rr+r][col];
                    end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic config_frame(input int w, input int h);
        @(posedge clk);
        #1;
        Feature_Width        = 8'(w);
        Feature_Height       = 8'(h);
        Feature_Width_Valid  = 1'b1;
        Feature_Height_Valid = 1'b1;
        strobe_cyc           = cyc;
        @(posedge clk);
        #1;
        Feature_Width_Valid  = 1'b0;
        Feature_Height_Valid = 1'b0;
    endtask

    task automatic drive_beat(input int rr, input int k);
        Line3_Inputs       = {pix[rr+2][k], pix[rr+1][k], pix[rr][k]};
        Line3_Inputs_Valid = 1'b1;
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 30 && done_cnt == d0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("frame_done_pulses", 128'(done_cnt - d0), 128'd1);
    endtask

    task automatic run_vec(input vec_t v, input bit check_first);
        int d0, w0, gap, beat;
        build_frame(v.w, v.h, v.rnd);
        w0 = win_cnt;
        d0 = done_cnt;
        win_base = w0;
        beat = 0;
        config_frame(v.w, v.h);
        for (int rr = 0; rr <= v.h - 3; rr++) begin
            for (int k = 0; k < v.w; k++) begin
                gap = (v.gap < 0) ? int'($urandom_range(2, 0)) : v.gap;
                repeat (gap) begin
                    Line3_Inputs_Valid = 1'b0;
                    Line3_Inputs       = 24'($urandom);
                    @(posedge clk);
                    #1;
                end
                drive_beat(rr, k);
                if (beat == v.strobe_at) begin
                    Feature_Width        = 8'd9;
                    Feature_Height       = 8'd9;
                    Feature_Width_Valid  = 1'b1;
                    Feature_Height_Valid = 1'b1;
                end
                @(posedge clk);
                #1;
                Feature_Width_Valid  = 1'b0;
                Feature_Height_Valid = 1'b0;
                beat++;
            end
        end
        Line3_Inputs_Valid = 1'b0;
        wait_done(d0);
        check("window_count", 128'(win_cnt - w0), 128'(PAD ? v.exp_pad : v.exp_nopad));
        check("windows_outstanding", 128'(exp_q.size()), 128'd0);
        check("done_after_last_window", 128'(done_cyc - last_valid_cyc), 128'd1);
        if (check_first)
            check("first_window", 128'(first_win),
                  PAD ? 128'h21_20_00_11_10_00_01_00_00 : 128'h22_21_20_12_11_10_02_01_00);
    endtask

    initial begin
        vec_t vecs [8];
        int   d0, w0;
        bit   reached;

        vecs[0] = '{w: 4,  h: 4, gap: 0,  rnd: 1'b0, strobe_at: -1, exp_nopad: 4,  exp_pad: 8};
        vecs[1] = '{w: 4,  h: 4, gap: 2,  rnd: 1'b0, strobe_at: -1, exp_nopad: 4,  exp_pad: 8};
        vecs[2] = '{w: 4,  h: 4, gap: 0,  rnd: 1'b0, strobe_at: 3,  exp_nopad: 4,  exp_pad: 8};
        vecs[3] = '{w: 7,  h: 5, gap: -1, rnd: 1'b1, strobe_at: -1, exp_nopad: 15, exp_pad: 21};
        vecs[4] = '{w: 3,  h: 3, gap: 0,  rnd: 1'b1, strobe_at: -1, exp_nopad: 1,  exp_pad: 3};
        vecs[5] = '{w: 10, h: 6, gap: -1, rnd: 1'b1, strobe_at: -1, exp_nopad: 32, exp_pad: 40};
        vecs[6] = '{w: 5,  h: 3, gap: 1,  rnd: 1'b1, strobe_at: -1, exp_nopad: 3,  exp_pad: 5};
        vecs[7] = '{w: 3,  h: 8, gap: -1, rnd: 1'b1, strobe_at: 7,  exp_nopad: 6,  exp_pad: 18};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {Window_Outputs_Valid, Frame_Done, Window_Col, Window_Row, Window_Outputs}, '0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i == 0);

        // Undersized frame: no windows, Frame_Done two cycles after the strobe, later beats dropped.
        build_frame(2, 8, 1'b0);
        w0 = win_cnt;
        d0 = done_cnt;
        config_frame(2, 8);
        wait_done(d0);
        check("tiny_done_latency", 128'(done_cyc - strobe_cyc), 128'd2);
        for (int k = 0; k < 6; k++) begin
            drive_beat(0, k);
            @(posedge clk);
            #1;
        end
        Line3_Inputs_Valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("tiny_no_windows", 128'(win_cnt - w0), 128'd0);
        check("tiny_no_extra_done", 128'(done_cnt - d0), 128'd1);

        // Abort after three windows, then rerun the same frame from scratch.
        build_frame(4, 4, 1'b0);
        w0 = win_cnt;
        d0 = done_cnt;
        reached = 1'b0;
        config_frame(4, 4);
        for (int b = 0; b < 8 && !reached; b++) begin
            drive_beat(b / 4, b % 4);
            @(posedge clk);
            #6;
            reached = (win_cnt - w0 >= 3);
        end
        check("abort_point_reached", 128'(reached), 128'd1);
        reset_n = 1'b0;
        Line3_Inputs_Valid = 1'b0;
        #1;
        check("async_reset_outputs", {Window_Outputs_Valid, Frame_Done, Window_Col, Window_Row, Window_Outputs}, '0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("no_done_on_abort", 128'(done_cnt - d0), 128'd0);
        run_vec(vecs[0], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
